// File: rtl/digit_scan_ctrl.sv
// Eight-digit seven-segment scan controller driving a 3-to-8 active-low
// digit decoder (select + {G1,G2} enable) and a shared active-low segment bus.
// Host loads are double-buffered and applied only at frame start.
module digit_scan_ctrl #(
  parameter int unsigned SCAN_CYCLES  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter int unsigned CNT_W        = 17
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iLoad,
  input  logic [31:0] iValue,
  input  logic [7:0]  iMask,
  input  logic [7:0]  iDp,
  output logic [2:0]  oSel,
  output logic [1:0]  oEna,
  output logic [7:0]  oSeg,
  output logic        oFrame,
  output logic        oPending
);

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       sel_nxt;
  logic             transfer;
  logic             frame_nxt;
  logic             pending_nxt;

  logic [31:0]      act_value, pend_value, act_value_nxt;
  logic [7:0]       act_mask, pend_mask, act_mask_nxt;
  logic [7:0]       act_dp, pend_dp, act_dp_nxt;

  logic [3:0]       nib;
  logic [1:0]       ena_nxt;
  logic [7:0]       seg_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Dwell timing, digit advance and frame-start transfer decision.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    sel_nxt   = oSel;
    transfer  = 1'b0;
    frame_nxt = 1'b0;
    case (state)
      BLANK: begin
        if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
          state_nxt = SHOW;
          cnt_nxt   = '0;
          if (oSel == 3'd0) begin
            frame_nxt = 1'b1;
            transfer  = oPending;
          end
        end
      end
      SHOW: begin
        if (cnt == CNT_W'(SCAN_CYCLES - 1)) begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
          sel_nxt   = oSel + 3'd1;
        end
      end
      default: begin
        state_nxt = BLANK;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Next active buffer and the outputs for the upcoming state; the transfer
  // reads pending before any coincident load overwrites it.
  always_comb begin
    act_value_nxt = transfer ? pend_value : act_value;
    act_mask_nxt  = transfer ? pend_mask  : act_mask;
    act_dp_nxt    = transfer ? pend_dp    : act_dp;
    pending_nxt   = iLoad ? 1'b1 : (transfer ? 1'b0 : oPending);
    nib           = act_value_nxt[{sel_nxt, 2'b00} +: 4];
    ena_nxt       = 2'b01;
    seg_nxt       = '1;
    if (state_nxt == SHOW && act_mask_nxt[sel_nxt]) begin
      ena_nxt = 2'b10;
      seg_nxt = {~act_dp_nxt[sel_nxt], hex7(nib)};
    end
  end

  // Scan state register.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= BLANK;
      cnt   <= '0;
      oSel  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      oSel  <= sel_nxt;
    end
  end

  // Display buffers and registered decoder/segment outputs.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      act_value  <= '0;
      act_mask   <= '0;
      act_dp     <= '0;
      pend_value <= '0;
      pend_mask  <= '0;
      pend_dp    <= '0;
      oEna       <= 2'b01;
      oSeg       <= '1;
      oFrame     <= 1'b0;
      oPending   <= 1'b0;
    end else begin
      act_value <= act_value_nxt;
      act_mask  <= act_mask_nxt;
      act_dp    <= act_dp_nxt;
      if (iLoad) begin
        pend_value <= iValue;
        pend_mask  <= iMask;
        pend_dp    <= iDp;
      end
      oEna     <= ena_nxt;
      oSeg     <= seg_nxt;
      oFrame   <= frame_nxt;
      oPending <= pending_nxt;
    end
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Randomized bench for digit_scan_ctrl with SCAN_CYCLES=4, BLANK_CYCLES=1.
// The reference model tracks elapsed cycles since reset and derives the
// digit, phase and frame start arithmetically from that count.
module tb_digit_scan_ctrl;

  localparam int unsigned SCAN  = 4;
  localparam int unsigned BLNK  = 1;
  localparam int unsigned DIG   = SCAN + BLNK;
  localparam int unsigned FRAME = 8 * DIG;

  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iLoad = 1'b0;
  logic [31:0] iValue = '0;
  logic [7:0]  iMask = '0;
  logic [7:0]  iDp = '0;
  logic [2:0]  oSel;
  logic [1:0]  oEna;
  logic [7:0]  oSeg;
  logic        oFrame;
  logic        oPending;

  digit_scan_ctrl #(.SCAN_CYCLES(SCAN), .BLANK_CYCLES(BLNK), .CNT_W(3)) dut (
    .iClk(iClk), .iRst(iRst), .iLoad(iLoad), .iValue(iValue), .iMask(iMask), .iDp(iDp),
    .oSel(oSel), .oEna(oEna), .oSeg(oSeg), .oFrame(oFrame), .oPending(oPending)
  );

  always #5 iClk = ~iClk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Model: cycles since reset, active display, pending display.
  int unsigned t = 0;
  logic [31:0] m_av = '0, m_pv = '0;
  logic [7:0]  m_am = '0, m_pm = '0, m_ad = '0, m_pd = '0;
  logic        m_pf = 1'b0;
  logic [14:0] got, exp;

  function automatic logic [14:0] expected();
    int unsigned k;
    logic show;
    logic [1:0] ena;
    logic [7:0] seg;
    logic [31:0] v;
    k    = (t / DIG) % 8;
    show = (t % DIG) != 0;
    ena  = 2'b01;
    seg  = 8'hFF;
    v    = m_av >> (4 * k);
    if (show && m_am[k]) begin
      ena = 2'b10;
      seg = {~m_ad[k], HEX[v[3:0]]};
    end
    return {3'(k), ena, seg, (t % FRAME) == 1, m_pf};
  endfunction

  function automatic logic [14:0] observed();
    return {oSel, oEna, oSeg, oFrame, oPending};
  endfunction

  // One clock with the given inputs; the model advances alongside.
  task automatic step(input logic rst, input logic ld, input logic [31:0] v,
                      input logic [7:0] m, input logic [7:0] d);
    iRst = rst; iLoad = ld; iValue = v; iMask = m; iDp = d;
    @(posedge iClk);
    if (rst) begin
      t = 0; m_av = '0; m_am = '0; m_ad = '0;
      m_pv = '0; m_pm = '0; m_pd = '0; m_pf = 1'b0;
    end else begin
      t++;
      if ((t % FRAME) == 1 && m_pf) begin
        m_av = m_pv; m_am = m_pm; m_ad = m_pd; m_pf = 1'b0;
      end
      if (ld) begin
        m_pv = v; m_pm = m; m_pd = d; m_pf = 1'b1;
      end
    end
    #1;
    iLoad = 1'b0;
  endtask

  task automatic idle_to(input int unsigned phase);
    for (int i = 0; i < int'(FRAME) + 1; i++) begin
      if ((t % FRAME) == phase) break;
      step(1'b0, 1'b0, '0, '0, '0);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, '0, '0, '0);
      got = observed();
      vectors++;
      if (got !== {3'd0, 2'b01, 8'hFF, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL reset_value got=%h exp=%h", got, {3'd0, 2'b01, 8'hFF, 1'b0, 1'b0});
      end
    end
    for (int i = 0; i < 45; i++) begin
      step(1'b0, 1'b0, '0, '0, '0);
      got = observed(); exp = expected();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL reset_dark t=%0d got=%h exp=%h", t, got, exp);
      end
    end
  endtask

  task automatic test_basic_scan();
    step(1'b0, 1'b1, 32'h76543210, 8'hFF, 8'h00);
    for (int i = 0; i < 2 * int'(FRAME) + 5; i++) begin
      step(1'b0, 1'b0, '0, '0, '0);
      got = observed(); exp = expected();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL basic_scan t=%0d got=%h exp=%h", t, got, exp);
      end
    end
  endtask

  task automatic test_mask_dp();
    step(1'b0, 1'b1, 32'h88888888, 8'h0F, 8'h01);
    for (int i = 0; i < 2 * int'(FRAME) + 3; i++) begin
      step(1'b0, 1'b0, '0, '0, '0);
      got = observed(); exp = expected();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL mask_dp t=%0d got=%h exp=%h", t, got, exp);
      end
    end
  endtask

  task automatic test_mid_frame();
    idle_to(17);
    step(1'b0, 1'b1, 32'hFFFFFFFF, 8'hFF, 8'h00);
    for (int i = 0; i < int'(FRAME) + 10; i++) begin
      step(1'b0, 1'b0, '0, '0, '0);
      got = observed(); exp = expected();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL mid_frame t=%0d got=%h exp=%h", t, got, exp);
      end
    end
  endtask

  task automatic test_overwrite();
    idle_to(3);
    step(1'b0, 1'b1, 32'h11111111, 8'hFF, 8'h00);
    repeat ($urandom_range(1, 20)) step(1'b0, 1'b0, '0, '0, '0);
    step(1'b0, 1'b1, 32'h22222222, 8'hFF, 8'h00);
    for (int i = 0; i < int'(FRAME) + 5; i++) begin
      step(1'b0, 1'b0, '0, '0, '0);
      got = observed(); exp = expected();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL overwrite t=%0d got=%h exp=%h", t, got, exp);
      end
    end
  endtask

  task automatic test_coincident();
    step(1'b0, 1'b1, 32'h33333333, 8'hFF, 8'h00);
    idle_to(0);
    step(1'b0, 1'b1, 32'hABCDEF01, 8'hF0, 8'hA5);
    vectors++;
    if (oPending !== 1'b1 || oFrame !== 1'b1) begin
      miscompares++;
      $display("FAIL coincident_pending got=%b%b exp=11", oPending, oFrame);
    end
    for (int i = 0; i < 2 * int'(FRAME); i++) begin
      step(1'b0, 1'b0, '0, '0, '0);
      got = observed(); exp = expected();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL coincident t=%0d got=%h exp=%h", t, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    idle_to(22);
    step(1'b0, 1'b1, 32'h5A5A5A5A, 8'hFF, 8'hFF);
    idle_to(27);
    step(1'b1, 1'b0, '0, '0, '0);
    got = observed();
    vectors++;
    if (got !== {3'd0, 2'b01, 8'hFF, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_mid got=%h exp=%h", got, {3'd0, 2'b01, 8'hFF, 1'b0, 1'b0});
    end
    for (int i = 0; i < int'(FRAME) + 2; i++) begin
      step(1'b0, 1'b0, '0, '0, '0);
      got = observed(); exp = expected();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL reset_mid_after t=%0d got=%h exp=%h", t, got, exp);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0,
           $urandom, 8'($urandom), 8'($urandom));
      got = observed(); exp = expected();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL random t=%0d got=%h exp=%h", t, got, exp);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic_scan();
    test_mask_dp();
    test_mid_frame();
    test_overwrite();
    test_coincident();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
